mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
Operand store and sequencer for the board-level sum-of-products datapath, result = a*b + c*d.
- Holds four 8-bit operands a, b, c, d, loaded one at a time from the switch/key front end.
- Time-shares a single external 8x8 multiplier over two passes instead of instantiating two.
- Start/busy/done handshake; the 17-bit result feeds the HEX/LEDR display mux.

Parameters:
MUL_LAT, 1, cycles from stable mul_a/mul_b to valid mul_p; legal range 1..4.

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
load_en  input  1  single-cycle pulse; writes data_in to the operand chosen by load_sel
load_sel  input  2  operand select: 0=a, 1=b, 2=c, 3=d
data_in  input  8  operand value
start  input  1  single-cycle pulse requesting a computation
rd_sel  input  2  operand readback select (same encoding as load_sel)
rd_data  output  8  combinational readback of the selected operand register
mul_a  output  8  shared multiplier operand A
mul_b  output  8  shared multiplier operand B
mul_p  input  16  shared multiplier product
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when result is updated
load_err  output  1  one-cycle pulse when load_en arrives while busy
result  output  17  a*b + c*d; bit 16 is the carry and drives LEDR[9]

Behaviour:
- Reset, when asserted at a clock edge:
  - a, b, c, d, accumulator and result are cleared to 0.
  - State goes to IDLE; busy, done and load_err = 0; mul_a = mul_b = 0.
- Reset dominates all other inputs, including mid-computation. The computation is aborted with no done pulse.
- Operand loads:
  - Accepted only in IDLE: operand[load_sel] <= data_in at the edge.
  - load_en while busy: operands unchanged; load_err = 1 on the next cycle only.
- States: IDLE -> RUN_AB -> RUN_CD -> DONE -> IDLE.
- IDLE:
  - mul_a = mul_b = 0.
  - start = 1 -> RUN_AB; the cycle counter is cleared.
  - load_en and start in the same cycle: the load is written, and the computation uses the newly loaded value.
- RUN_AB:
  - mul_a = a, mul_b = b, held for exactly MUL_LAT cycles.
  - On the last of those cycles: acc <= {1'b0, mul_p}, then -> RUN_CD.
- RUN_CD:
  - mul_a = c, mul_b = d for MUL_LAT cycles.
  - On the last cycle: result <= acc + {1'b0, mul_p}, using a 17-bit add with no truncation; then -> DONE.
- DONE:
  - done = 1 for this single cycle; busy still 1.
  - -> IDLE unconditionally.
- start while busy (including in DONE) is ignored and not queued.
- Latency from the start-sampling edge to done high = 2*MUL_LAT + 1 cycles; done is high in the cycle after result updates.
- result holds its value until the next completed computation or reset. It is never cleared by start.
- Width and range: maximum result = 2*255*255 = 130050 = 0x1FC02, which fits in 17 bits, so there is no overflow case.
- rd_data is purely combinational from the operand registers and valid in every state.
- The cycle counter is ceil(log2(MUL_LAT+1)) bits and is cleared on every state entry.

Test Plan:
1. Reset, then load a=0x12, b=0x34, c=0x56, d=0x78; start with MUL_LAT=1 -> busy for 3 cycles, done 3 cycles after start, result=0x02BF8 (936+10320=11256), bit16=0.
2. Load all four operands as 0xFF; start -> result=0x1FC02, carry bit 16=1.
3. MUL_LAT=3 with a multiplier model delayed 3 cycles; values as in scenario 1 -> done exactly 7 cycles after start, result=0x02BF8, and mul_a/mul_b stable for 3 cycles per pass.
4. During RUN_AB, pulse load_en with sel=0, data=0x00, and pulse start -> load_err pulses once, a stays 0x12, result is still 0x02BF8, and only one done pulse occurs.
5. Assert reset in RUN_CD -> next cycle busy=0, done never pulses, result=0, and rd_data=0 for all rd_sel.
6. In IDLE with a=0x02, b=0x03, c=0x00, d=0x00, assert load_en (sel=2, data=0x04) and start in the same cycle -> result=6+0=0x00006 (d=0). Then load d=0x05 and start -> result=0x0001A.

Source files
------------

// File: rtl/mac_sequencer.sv
// Operand store and two-pass sequencer for result = a*b + c*d.
// A single external multiplier is shared: pass one computes a*b, pass two computes c*d.
module mac_sequencer #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [1:0]  load_sel,
  input  logic [7:0]  data_in,
  input  logic        start,
  input  logic [1:0]  rd_sel,
  output logic [7:0]  rd_data,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic        busy,
  output logic        done,
  output logic        load_err,
  output logic [16:0] result
);

  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN_AB, RUN_CD, DONE} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]  r_opnd [4];
  logic [16:0] r_acc;

  logic        w_load_ok;
  logic        w_last;
  logic [7:0]  w_a_nxt;
  logic [7:0]  w_b_nxt;

  // A load in the same cycle as start must reach the multiplier in the first pass,
  // so the operand values are forwarded from data_in before they land in r_opnd.
  // NOTE: every signal gets a default at the top of always_comb so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_load_ok = load_en && (r_state == IDLE);
    w_last    = (r_cnt == CW'(MUL_LAT - 1));
    w_a_nxt   = r_opnd[0];
    w_b_nxt   = r_opnd[1];
    if (w_load_ok && load_sel == 2'd0) w_a_nxt = data_in;
    if (w_load_ok && load_sel == 2'd1) w_b_nxt = data_in;
  end

  assign rd_data = r_opnd[rd_sel];

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the operand array is a handful of flops, not a RAM, so clearing it
      // on reset costs nothing and gives a defined readback.
      for (int i = 0; i < 4; i++) r_opnd[i] <= '0;
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      result   <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= load_en && (r_state != IDLE);
      if (w_load_ok) r_opnd[load_sel] <= data_in;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN_AB;
            r_cnt   <= '0;
            busy    <= 1'b1;
            mul_a   <= w_a_nxt;
            mul_b   <= w_b_nxt;
          end
        end
        RUN_AB: begin
          if (w_last) begin
            r_acc   <= {1'b0, mul_p};
            r_state <= RUN_CD;
            r_cnt   <= '0;
            mul_a   <= r_opnd[2];
            mul_b   <= r_opnd[3];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RUN_CD: begin
          if (w_last) begin
            result  <= r_acc + {1'b0, mul_p};
            r_state <= DONE;
            r_cnt   <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: two instances (MUL_LAT=1 and MUL_LAT=3) share stimulus and are
// checked against an arithmetic model of the operands and the expected timing.
module tb_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset1, reset3, load_en, start;
  logic [1:0]  load_sel, rd_sel;
  logic [7:0]  data_in;
  logic [7:0]  rd_data1, mul_a1, mul_b1, rd_data3, mul_a3, mul_b3;
  logic [15:0] mul_p1, mul_p3, p3_s1, p3_s2;
  logic        busy1, done1, load_err1, busy3, done3, load_err3;
  logic [16:0] result1, result3;

  mac_sequencer #(.MUL_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset1), .load_en(load_en), .load_sel(load_sel), .data_in(data_in),
    .start(start), .rd_sel(rd_sel), .rd_data(rd_data1), .mul_a(mul_a1), .mul_b(mul_b1),
    .mul_p(mul_p1), .busy(busy1), .done(done1), .load_err(load_err1), .result(result1));

  mac_sequencer #(.MUL_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset3), .load_en(load_en), .load_sel(load_sel), .data_in(data_in),
    .start(start), .rd_sel(rd_sel), .rd_data(rd_data3), .mul_a(mul_a3), .mul_b(mul_b3),
    .mul_p(mul_p3), .busy(busy3), .done(done3), .load_err(load_err3), .result(result3));

  // External multipliers: combinational for latency 1, two register stages for latency 3.
  assign mul_p1 = 16'(mul_a1) * 16'(mul_b1);
  always @(posedge clk) begin
    p3_s1 <= 16'(mul_a3) * 16'(mul_b3);
    p3_s2 <= p3_s1;
  end
  assign mul_p3 = p3_s2;

  int m_op [4];
  int n_pass = 0;
  int n_total = 0;

  function automatic int model_result();
    return m_op[0] * m_op[1] + m_op[2] * m_op[3];
  endfunction

  task automatic load_op(input int sel, input int val);
    @(negedge clk);
    load_en  = 1'b1;
    load_sel = 2'(sel);
    data_in  = 8'(val);
    @(negedge clk);
    load_en  = 1'b0;
    m_op[sel] = val;
  endtask

  task automatic check_rd(input string name);
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      n_total++;
      if (rd_data1 !== 8'(m_op[s])) $display("FAIL %s rd_data L1 sel%0d: got %h want %h", name, s, rd_data1, 8'(m_op[s]));
      else n_pass++;
      n_total++;
      if (rd_data3 !== 8'(m_op[s])) $display("FAIL %s rd_data L3 sel%0d: got %h want %h", name, s, rd_data3, 8'(m_op[s]));
      else n_pass++;
    end
  endtask

  // One computation on both instances; optional same-cycle load, optional disturbance in RUN_AB.
  task automatic run_op(input string name, input bit with_load, input int sel, input int val, input bit disturb);
    int d1_cnt = 0, d1_cyc = 0, d3_cnt = 0, d3_cyc = 0, b1_cnt = 0, b3_cnt = 0;
    int le1 = 0, le3 = 0, mul_bad = 0, exp_res;
    @(negedge clk);
    start = 1'b1;
    if (with_load) begin
      load_en = 1'b1; load_sel = 2'(sel); data_in = 8'(val);
      m_op[sel] = val;
    end
    exp_res = model_result();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; load_en = 1'b0;
        if (disturb) begin load_en = 1'b1; load_sel = 2'd0; data_in = 8'h00; start = 1'b1; end
      end else if (k == 2) begin
        start = 1'b0; load_en = 1'b0;
      end
      if (done1) begin d1_cnt++; d1_cyc = k; end
      if (done3) begin d3_cnt++; d3_cyc = k; end
      if (busy1) b1_cnt++;
      if (busy3) b3_cnt++;
      if (load_err1) le1++;
      if (load_err3) le3++;
      if (k == 1 && (mul_a1 !== 8'(m_op[0]) || mul_b1 !== 8'(m_op[1]))) mul_bad++;
      if (k == 2 && (mul_a1 !== 8'(m_op[2]) || mul_b1 !== 8'(m_op[3]))) mul_bad++;
      if (k >= 1 && k <= 3 && (mul_a3 !== 8'(m_op[0]) || mul_b3 !== 8'(m_op[1]))) mul_bad++;
      if (k >= 4 && k <= 6 && (mul_a3 !== 8'(m_op[2]) || mul_b3 !== 8'(m_op[3]))) mul_bad++;
    end
    n_total++; if (d1_cnt !== 1) $display("FAIL %s done pulses L1: got %0d want 1", name, d1_cnt); else n_pass++;
    n_total++; if (d1_cyc !== 3) $display("FAIL %s done cycle L1: got %0d want 3", name, d1_cyc); else n_pass++;
    n_total++; if (b1_cnt !== 3) $display("FAIL %s busy cycles L1: got %0d want 3", name, b1_cnt); else n_pass++;
    n_total++; if (d3_cnt !== 1) $display("FAIL %s done pulses L3: got %0d want 1", name, d3_cnt); else n_pass++;
    n_total++; if (d3_cyc !== 7) $display("FAIL %s done cycle L3: got %0d want 7", name, d3_cyc); else n_pass++;
    n_total++; if (b3_cnt !== 7) $display("FAIL %s busy cycles L3: got %0d want 7", name, b3_cnt); else n_pass++;
    n_total++; if (result1 !== 17'(exp_res)) $display("FAIL %s result L1: got %h want %h", name, result1, 17'(exp_res)); else n_pass++;
    n_total++; if (result3 !== 17'(exp_res)) $display("FAIL %s result L3: got %h want %h", name, result3, 17'(exp_res)); else n_pass++;
    n_total++; if (le1 !== int'(disturb)) $display("FAIL %s load_err pulses L1: got %0d want %0d", name, le1, int'(disturb)); else n_pass++;
    n_total++; if (le3 !== int'(disturb)) $display("FAIL %s load_err pulses L3: got %0d want %0d", name, le3, int'(disturb)); else n_pass++;
    n_total++; if (mul_bad !== 0) $display("FAIL %s multiplier operand cycles wrong: got %0d want 0", name, mul_bad); else n_pass++;
    n_total++;
    if ({mul_a1, mul_b1, mul_a3, mul_b3} !== 32'h0) $display("FAIL %s idle mul operands: got %h want 0", name, {mul_a1, mul_b1, mul_a3, mul_b3});
    else n_pass++;
    check_rd(name);
  endtask

  task automatic test_reset();
    reset1 = 1'b1; reset3 = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) m_op[s] = 0;
    n_total++; if ({busy1, done1, load_err1} !== 3'b000) $display("FAIL reset flags L1: got %b want 000", {busy1, done1, load_err1}); else n_pass++;
    n_total++; if ({busy3, done3, load_err3} !== 3'b000) $display("FAIL reset flags L3: got %b want 000", {busy3, done3, load_err3}); else n_pass++;
    n_total++; if (result1 !== 17'h0) $display("FAIL reset result L1: got %h want 0", result1); else n_pass++;
    n_total++; if (result3 !== 17'h0) $display("FAIL reset result L3: got %h want 0", result3); else n_pass++;
    n_total++;
    if ({mul_a1, mul_b1, mul_a3, mul_b3} !== 32'h0) $display("FAIL reset mul operands: got %h want 0", {mul_a1, mul_b1, mul_a3, mul_b3});
    else n_pass++;
    check_rd("reset");
    reset1 = 1'b0; reset3 = 1'b0;
  endtask

  task automatic test_basic();
    load_op(0, 8'h12); load_op(1, 8'h34); load_op(2, 8'h56); load_op(3, 8'h78);
    run_op("basic", 1'b0, 0, 0, 1'b0);
    n_total++; if (result1 !== 17'h02BF8) $display("FAIL basic known result: got %h want 02bf8", result1); else n_pass++;
  endtask

  task automatic test_carry();
    for (int s = 0; s < 4; s++) load_op(s, 8'hFF);
    run_op("carry", 1'b0, 0, 0, 1'b0);
    n_total++; if (result3[16] !== 1'b1) $display("FAIL carry bit16 L3: got %b want 1", result3[16]); else n_pass++;
  endtask

  task automatic test_busy_reject();
    load_op(0, 8'h12); load_op(1, 8'h34); load_op(2, 8'h56); load_op(3, 8'h78);
    run_op("busy_reject", 1'b0, 0, 0, 1'b1);
    n_total++; if (result3 !== 17'h02BF8) $display("FAIL busy_reject known result: got %h want 02bf8", result3); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d1_cnt = 0, d3_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2) reset1 = 1'b1;
      if (k == 5) reset3 = 1'b1;
      if (k == 3) begin
        reset1 = 1'b0;
        n_total++; if (busy1 !== 1'b0) $display("FAIL reset_mid busy after reset L1: got %b want 0", busy1); else n_pass++;
      end
      if (k == 6) begin
        reset3 = 1'b0;
        n_total++; if (busy3 !== 1'b0) $display("FAIL reset_mid busy after reset L3: got %b want 0", busy3); else n_pass++;
      end
      if (done1) d1_cnt++;
      if (done3) d3_cnt++;
    end
    for (int s = 0; s < 4; s++) m_op[s] = 0;
    n_total++; if (d1_cnt !== 0) $display("FAIL reset_mid done pulses L1: got %0d want 0", d1_cnt); else n_pass++;
    n_total++; if (d3_cnt !== 0) $display("FAIL reset_mid done pulses L3: got %0d want 0", d3_cnt); else n_pass++;
    n_total++; if (result1 !== 17'h0) $display("FAIL reset_mid result L1: got %h want 0", result1); else n_pass++;
    n_total++; if (result3 !== 17'h0) $display("FAIL reset_mid result L3: got %h want 0", result3); else n_pass++;
    check_rd("reset_mid");
  endtask

  task automatic test_load_start();
    load_op(0, 8'h02); load_op(1, 8'h03); load_op(2, 8'h00); load_op(3, 8'h00);
    run_op("load_start", 1'b1, 2, 8'h04, 1'b0);
    n_total++; if (result1 !== 17'h00006) $display("FAIL load_start known result: got %h want 00006", result1); else n_pass++;
    load_op(3, 8'h05);
    run_op("load_d", 1'b0, 0, 0, 1'b0);
    n_total++; if (result3 !== 17'h0001A) $display("FAIL load_d known result: got %h want 0001a", result3); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int s = 0; s < 4; s++) load_op(s, int'($urandom_range(0, 255)));
      run_op("random", it[0], int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset1 = 1'b1; reset3 = 1'b1;
    load_en = 1'b0; start = 1'b0;
    load_sel = 2'd0; data_in = 8'h00; rd_sel = 2'd0;
    test_reset();
    test_basic();
    test_carry();
    test_busy_reject();
    test_reset_mid();
    test_load_start();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
